// File: rtl/slicel_cfg_pkg.sv
// Shared types and layout helpers for the slice configuration loader.
// The cfg_vec layout, LSB to MSB, is: LUT configs, inter-LUT mux config,
// use_cc, reg init.
package slicel_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT,
        DONE
    } cfg_state_t;

    // Config bits per LUT cell: two base-width truth tables plus one select bit.
    function automatic int lut_cfg_bits(input int s_xx_base);
        return 2 * (2 ** s_xx_base) + 1;
    endfunction

    function automatic int mux_lvls(input int num_luts);
        return $clog2(num_luts);
    endfunction

    function automatic int lut_ofs(input int s_xx_base, input int lut_idx);
        return lut_idx * lut_cfg_bits(s_xx_base);
    endfunction

    function automatic int mux_ofs(input int s_xx_base, input int num_luts);
        return num_luts * lut_cfg_bits(s_xx_base);
    endfunction

    function automatic int usecc_ofs(input int s_xx_base, input int num_luts);
        return mux_ofs(s_xx_base, num_luts) + mux_lvls(num_luts);
    endfunction

    function automatic int init_ofs(input int s_xx_base, input int num_luts);
        return usecc_ofs(s_xx_base, num_luts) + 1;
    endfunction

    // Two init bits per LUT follow the single use_cc bit.
    function automatic int cfg_w(input int s_xx_base, input int num_luts);
        return init_ofs(s_xx_base, num_luts) + 2 * num_luts;
    endfunction

    function automatic int nwords(input int s_xx_base, input int num_luts, input int word_w);
        return (cfg_w(s_xx_base, num_luts) + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/slicel_cfg_chk.sv
// Running XOR checksum over the payload words and comparison against the
// trailing checksum word. Only instantiated when SLICEL_CFG_CHECKSUM_EN is set.
module slicel_cfg_chk #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              trl_en,
    input  logic [WORD_W-1:0] data,
    output logic              match
);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] trl_q;

    // Accumulate payload words and capture the trailer; cleared at each session start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            trl_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            trl_q <= '0;
        end else begin
            if (acc_en) begin
                acc_q <= acc_q ^ data;
            end
            if (trl_en) begin
                trl_q <= data;
            end
        end
    end

    assign match = (acc_q == trl_q);

endmodule

// File: rtl/slicel_cfg_loader.sv
// Configuration sequencer for one logic slice: streams the bitstream into a
// shadow register, then commits it with a one-cycle cfg_cen pulse while the
// slice's user register enable is held off.
// Optional macro SLICEL_CFG_CHECKSUM_EN: expects one trailing XOR checksum word
// and verifies it in a CHECK state before committing.
module slicel_cfg_loader
    import slicel_cfg_pkg::*;
#(
    parameter int  S_XX_BASE = 4,
    parameter int  NUM_LUTS  = 4,
    parameter int  WORD_W    = 8,
    localparam int CFG_W     = cfg_w(S_XX_BASE, NUM_LUTS),
    localparam int NWORDS    = nwords(S_XX_BASE, NUM_LUTS, WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              bs_valid,
    output logic              bs_ready,
    input  logic [WORD_W-1:0] bs_data,
    output logic [CFG_W-1:0]  cfg_vec,
    output logic              cfg_cen,
    input  logic              user_reg_ce,
    output logic              slice_reg_ce,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef SLICEL_CFG_CHECKSUM_EN
    localparam int LAST_IDX = NWORDS;
`else
    localparam int LAST_IDX = NWORDS - 1;
`endif
    localparam int CNT_W = $clog2(NWORDS + 1) + 1;

    cfg_state_t       state_q;
    cfg_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             start_ok;
    logic             xfer;
    logic             last_word;
    logic             err_q;
    logic [CFG_W-1:0] shadow;

    assign start_ok  = (state_q == IDLE) && start;
    // abort outranks a word offered in the same cycle
    assign xfer      = (state_q == LOAD) && bs_valid && !abort;
    assign last_word = xfer && (cnt_q == CNT_W'(LAST_IDX));

`ifdef SLICEL_CFG_CHECKSUM_EN
    logic chk_match;

    slicel_cfg_chk #(
        .WORD_W (WORD_W)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .acc_en (xfer && (cnt_q < CNT_W'(NWORDS))),
        .trl_en (xfer && (cnt_q == CNT_W'(NWORDS))),
        .data   (bs_data),
        .match  (chk_match)
    );
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_d      = state_q;
        bs_ready     = 1'b0;
        busy         = 1'b1;
        cfg_cen      = 1'b0;
        done         = 1'b0;
        slice_reg_ce = 1'b0;
        case (state_q)
            IDLE: begin
                busy         = 1'b0;
                // user clocking only outside a session and never during reset
                slice_reg_ce = user_reg_ce && rst_n;
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bs_ready = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last_word) begin
`ifdef SLICEL_CFG_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = COMMIT;
`endif
                end
            end
`ifdef SLICEL_CFG_CHECKSUM_EN
            CHECK: begin
                if (abort || !chk_match) begin
                    state_d = IDLE;
                end else begin
                    state_d = COMMIT;
                end
            end
`endif
            COMMIT: begin
                cfg_cen = 1'b1;
                state_d = abort ? IDLE : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word counter: restarts with each session, advances per accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start_ok) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky error: cleared by a new session, set by a failed checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
`ifdef SLICEL_CFG_CHECKSUM_EN
        end else if ((state_q == CHECK) && !abort && !chk_match) begin
            err_q <= 1'b1;
`endif
        end
    end

    assign err = err_q;

    // Shadow register, one segment per bitstream word; the last segment keeps
    // only the bits that fit inside CFG_W.
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        localparam int LO = w * WORD_W;
        localparam int NB = ((CFG_W - LO) < WORD_W) ? (CFG_W - LO) : WORD_W;

        logic [NB-1:0] seg_q;

        // Capture this word's bits when the counter points at it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                seg_q <= '0;
            end else if (xfer && (cnt_q == CNT_W'(w))) begin
                seg_q <= bs_data[NB-1:0];
            end
        end

        assign shadow[LO +: NB] = seg_q;
    end

    assign cfg_vec = shadow;

endmodule
